// File: rtl/alu_iter_if.sv
// Request/response bundle for alu_iter: decode fields and operands in,
// result and branch flags out, each side with its own valid/ready pair.
interface alu_iter_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [2:0]      funct3;
    logic            op5;
    logic            funct7;
    logic            m_sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            flag_z;
    logic            flag_lt;
    logic            flag_ltu;

    modport master (
        output in_valid, op, funct3, op5, funct7, m_sel, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_lt, flag_ltu
    );

    modport slave (
        input  in_valid, op, funct3, op5, funct7, m_sel, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_lt, flag_ltu
    );
endinterface

// File: rtl/alu_iter.sv
// Iterative RV32I execute ALU: 1-cycle logic/add/sub, SHIFT_STEP-per-cycle shifts.
// Define ALU_MUL_EN to add the XLEN-cycle shift-add multiplier (M-ext MUL).
module alu_iter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    alu_iter_if.slave  bus
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t          state, nxt, go;
    logic [XLEN-1:0] res, sh_res;
    logic            fz, flt, fltu;
    logic            left, arith;
    logic [CW-1:0]   cnt, step;
    logic            accept;

    logic [XLEN-1:0] sum, diff, d_res;
    logic            d_z, d_lt, d_ltu;
    logic            d_shift, d_left, d_arith, d_mul;
    logic [SW-1:0]   shamt;

    assign bus.in_ready  = !rst && (state == IDLE ||
                           (state == DONE && bus.out_ready));
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res;
    assign bus.flag_z    = fz;
    assign bus.flag_lt   = flt;
    assign bus.flag_ltu  = fltu;

    assign accept = bus.in_valid && bus.in_ready;
    assign sum    = bus.a + bus.b;
    assign diff   = bus.a - bus.b;
    assign shamt  = bus.b[SW-1:0];

    always_comb begin
        d_res   = sum;
        d_z     = 1'b0;
        d_lt    = 1'b0;
        d_ltu   = 1'b0;
        d_shift = 1'b0;
        d_left  = 1'b0;
        d_arith = 1'b0;
        d_mul   = 1'b0;
        unique case (bus.op)
            2'd0: begin
                case (bus.funct3)
                    3'b000: d_res = (bus.op5 && bus.funct7) ? diff : sum;
                    3'b001: begin
                        d_res   = bus.a;
                        d_shift = 1'b1;
                        d_left  = 1'b1;
                    end
                    3'b010: d_res = XLEN'($signed(bus.a) < $signed(bus.b));
                    3'b011: d_res = XLEN'(bus.a < bus.b);
                    3'b100: d_res = bus.a ^ bus.b;
                    3'b101: begin
                        d_res   = bus.a;
                        d_shift = 1'b1;
                        d_arith = bus.funct7;
                    end
                    3'b110: d_res = bus.a | bus.b;
                    3'b111: d_res = bus.a & bus.b;
                endcase
`ifdef ALU_MUL_EN
                // M-ext row: only MUL is implemented, other funct3 yield 0
                if (bus.op5 && bus.m_sel) begin
                    d_res   = '0;
                    d_shift = 1'b0;
                    d_left  = 1'b0;
                    d_arith = 1'b0;
                    d_mul   = (bus.funct3 == 3'b000);
                end
`endif
            end
            2'd1: d_res = sum;
            default: begin
                d_res = diff;
                d_z   = (bus.a == bus.b);
                d_lt  = $signed(bus.a) < $signed(bus.b);
                d_ltu = bus.a < bus.b;
            end
        endcase
    end

`ifndef ALU_MUL_EN
    logic unused_msel;
    assign unused_msel = bus.m_sel;
`endif

    always_comb begin
        go = (d_shift && shamt != '0) ? SHIFT : DONE;
`ifdef ALU_MUL_EN
        if (d_mul) go = MUL;
`endif
    end

    assign step = (cnt < CW'(SHIFT_STEP)) ? cnt : CW'(SHIFT_STEP);

    always_comb begin
        if (left)
            sh_res = res << step;
        else if (arith)
            sh_res = $unsigned($signed(res) >>> step);
        else
            sh_res = res >> step;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (accept) nxt = go;
            DONE: begin
                if (accept)
                    nxt = go;
                else if (bus.out_ready)
                    nxt = IDLE;
            end
            SHIFT: if (cnt == step) nxt = DONE;
`ifdef ALU_MUL_EN
            MUL:   if (cnt == CW'(1)) nxt = DONE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mcand, mplier;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            mplier <= bus.b;
        end else if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res   <= '0;
            fz    <= 1'b0;
            flt   <= 1'b0;
            fltu  <= 1'b0;
            cnt   <= '0;
            left  <= 1'b0;
            arith <= 1'b0;
        end else if (accept) begin
            res   <= d_res;
            fz    <= d_z;
            flt   <= d_lt;
            fltu  <= d_ltu;
            cnt   <= CW'(shamt);
            left  <= d_left;
            arith <= d_arith;
`ifdef ALU_MUL_EN
            if (d_mul) cnt <= CW'(XLEN);
`endif
        end else if (state == SHIFT) begin
            res <= sh_res;
            cnt <= cnt - step;
        end
`ifdef ALU_MUL_EN
        else if (state == MUL) begin
            // res doubles as the product accumulator
            res <= res + (mplier[0] ? mcand : '0);
            cnt <= cnt - CW'(1);
        end
`endif
    end
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed corner cases then random traffic
// against an arithmetic reference model; honours ALU_MUL_EN when defined.
module tb_alu_iter;
    localparam int XLEN = 32;
    localparam int STEP = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_if #(.XLEN(XLEN)) bus();

    alu_iter #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [XLEN-1:0] res;
        logic            z;
        logic            lt;
        logic            ltu;
        int              lat;
        int              acc;
    } exp_t;

    exp_t sbq[$];
    exp_t head;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -1;
    int   last_pop = -2;
    int   idle_cnt = 0;
    bit   seen = 0;
    bit   rand_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic op5, input logic f7,
                                   input logic ms, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        exp_t e;
        int   sh;
        e.res = '0;
        e.z   = 1'b0;
        e.lt  = 1'b0;
        e.ltu = 1'b0;
        e.lat = 1;
        e.acc = 0;
        sh = int'(b % XLEN);
        if (ms == 1'b0 || ms == 1'b1) begin end
        if (op == 2'd1) begin
            e.res = a + b;
        end else if (op >= 2'd2) begin
            e.res = a - b;
            e.z   = (a == b);
            e.lt  = ($signed(a) < $signed(b));
            e.ltu = (a < b);
        end
`ifdef ALU_MUL_EN
        else if (op5 && ms) begin
            if (f3 == 3'd0) begin
                e.res = a * b;
                e.lat = XLEN + 1;
            end
        end
`endif
        else begin
            case (f3)
                3'd0: e.res = (op5 && f7) ? a - b : a + b;
                3'd1: e.res = a << sh;
                3'd2: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
                3'd3: e.res = (a < b) ? 1 : 0;
                3'd4: e.res = a ^ b;
                3'd5: begin
                    if (f7) e.res = $signed(a) >>> sh;
                    else    e.res = a >> sh;
                end
                3'd6: e.res = a | b;
                default: e.res = a & b;
            endcase
            if (f3 == 3'd1 || f3 == 3'd5)
                e.lat = 1 + (sh + STEP - 1) / STEP;
        end
        return e;
    endfunction

    // monitor: reset flushes, otherwise compare the head entry while valid
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            seen = 0;
            idle_cnt = 0;
        end else if (bus.out_valid) begin
            idle_cnt = 0;
            if (sbq.size() == 0) begin
                chk("unexpected_out", bus.out_valid, 0);
            end else begin
                head = sbq[0];
                if (!seen) begin
                    seen = 1;
                    chk("latency", cyc - head.acc, head.lat);
                end
                if (!bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
                chk("result", bus.result, head.res);
                chk("flags", {bus.flag_z, bus.flag_lt, bus.flag_ltu},
                    {head.z, head.lt, head.ltu});
                if (bus.out_ready) begin
                    void'(sbq.pop_front());
                    seen = 0;
                    last_pop = cyc;
                end
            end
        end else if (sbq.size() > 0) begin
            idle_cnt++;
            if (idle_cnt > 200) begin
                chk("out_timeout", bus.out_valid, 1);
                void'(sbq.pop_front());
                seen = 0;
                idle_cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.out_ready = ($urandom % 4) != 0;
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                         input logic op5, input logic f7, input logic ms,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        bus.op = op;
        bus.funct3 = f3;
        bus.op5 = op5;
        bus.funct7 = f7;
        bus.m_sel = ms;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        e = model(op, f3, op5, f7, ms, a, b);
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc = cyc;
                sbq.push_back(e);
                last_acc = cyc;
                done = 1;
            end else if (++n > 300) begin
                chk("accept_timeout", bus.in_ready, 1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // idle cycles with scrambled fields prove only accept-edge values matter
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.funct3 = 3'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = '0;
        bus.funct3 = '0;
        bus.op5 = 1'b0;
        bus.funct7 = 1'b0;
        bus.m_sel = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.flag_z, bus.flag_lt, bus.flag_ltu}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        issue(2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7);
        issue(2'd2, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(2'd3, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
        idle(0);
        drain();

        issue(2'd0, 3'b101, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
        idle(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sra_busy", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        drain();

        bus.out_ready = 1'b0;
        issue(2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            issue(2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
        join
        idle(0);
        chk("bp_same_edge", last_acc, last_pop);
        drain();

        issue(2'd0, 3'b001, 1'b0, 1'b0, 1'b0, 32'd3, 32'd20);
        idle(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(2'd0, 3'b011, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        issue(2'd0, 3'b000, 1'b1, 1'b0, 1'b1, 32'd3, 32'hFFFF_FFF9);
        idle(0);
        drain();

        rand_rdy = 1;
        for (int t = 0; t < 300; t++) begin
            logic [XLEN-1:0] ra, rb;
            int g;
            ra = $urandom;
            rb = ($urandom % 8 == 0) ? ra : $urandom;
            issue(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ra, rb);
            g = $urandom_range(0, 2);
            if (g > 0) idle(g);
        end
        idle(0);
        rand_rdy = 0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
